// File: rtl/axis_mux_pkg.sv
// rtl/axis_mux_pkg.sv - shared types and helpers for the AXIS packet arbiter mux
package axis_mux_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    localparam int BUS_SEL_EN_BIT = 7;

    // bus_sel code that selects channel idx with the enable bit set
    function automatic logic [7:0] choose_code(input logic [6:0] idx);
        return 8'd128 + {1'b0, idx};
    endfunction

    // First valid channel strictly after last, wrapping at n_ch-1 -> 0.
    // Only meaningful when at least one valid bit is set.
    function automatic logic [6:0] rr_next(input logic [63:0] valid,
                                           input logic [6:0]  last,
                                           input int          n_ch);
        logic [6:0] pick;
        logic       found;
        logic [5:0] idx;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            idx = 6'((int'(last) + k) % n_ch);
            if (!found && (k <= n_ch) && valid[idx]) begin
                pick  = {1'b0, idx};
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// rtl/axis_reg_slice.sv - single-stage AXIS register slice
// s_t*: upstream beat in, s_tready_o = slice can load this cycle
// m_t*: registered beat out, held while m_tvalid_o && !m_tready_i
module axis_reg_slice #(
    parameter int DATA_W = 32,
    parameter int KEEP_W = DATA_W / 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              s_tvalid_i,
    output logic              s_tready_o,
    input  logic [DATA_W-1:0] s_tdata_i,
    input  logic [KEEP_W-1:0] s_tkeep_i,
    input  logic              s_tlast_i,
    output logic              m_tvalid_o,
    input  logic              m_tready_i,
    output logic [DATA_W-1:0] m_tdata_o,
    output logic [KEEP_W-1:0] m_tkeep_o,
    output logic              m_tlast_o
);

    logic              tvalid_q, tvalid_d;
    logic [DATA_W-1:0] tdata_q,  tdata_d;
    logic [KEEP_W-1:0] tkeep_q,  tkeep_d;
    logic              tlast_q,  tlast_d;
    logic              load;

    // Empty or being drained this cycle: a new beat can replace the held one
    assign load       = !tvalid_q || m_tready_i;
    assign s_tready_o = load;

    always_comb begin
        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        tkeep_d  = tkeep_q;
        tlast_d  = tlast_q;
        if (load) begin
            tvalid_d = s_tvalid_i;
            if (s_tvalid_i) begin
                tdata_d = s_tdata_i;
                tkeep_d = s_tkeep_i;
                tlast_d = s_tlast_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            tkeep_q  <= '0;
            tlast_q  <= 1'b0;
        end else begin
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
            tkeep_q  <= tkeep_d;
            tlast_q  <= tlast_d;
        end
    end

    assign m_tvalid_o = tvalid_q;
    assign m_tdata_o  = tdata_q;
    assign m_tkeep_o  = tkeep_q;
    assign m_tlast_o  = tlast_q;

endmodule

// File: rtl/axis_pkt_arb_mux.sv
// rtl/axis_pkt_arb_mux.sv - N-input AXIS packet mux with per-packet lock
// bus_sel: {enable, channel} selection (MODE 0); s_axis_*: packed per-channel inputs
// m_axis_*: registered output; grant_idx/busy: current lock; pkt_done: tlast accepted
module axis_pkt_arb_mux
    import axis_mux_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int DATA_W = 32,
    parameter int KEEP_W = DATA_W / 8,
    parameter int MODE   = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               bus_sel,
    input  logic [N_CH-1:0]          s_axis_tvalid,
    output logic [N_CH-1:0]          s_axis_tready,
    input  logic [N_CH*DATA_W-1:0]   s_axis_tdata,
    input  logic [N_CH*KEEP_W-1:0]   s_axis_tkeep,
    input  logic [N_CH-1:0]          s_axis_tlast,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic [DATA_W-1:0]        m_axis_tdata,
    output logic [KEEP_W-1:0]        m_axis_tkeep,
    output logic                     m_axis_tlast,
    output logic [6:0]               grant_idx,
    output logic                     busy,
    output logic                     pkt_done
);

    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    state_e            state_q;
    logic [6:0]        grant_q;
    logic [6:0]        rr_last_q;

    logic [IDX_W-1:0]  sel_idx;
    logic [63:0]       valid_ext;
    logic              locked;
    logic              sel_valid;
    logic              sel_last;
    logic [DATA_W-1:0] sel_data;
    logic [KEEP_W-1:0] sel_keep;
    logic              slice_ready;
    logic              beat_acc;
    logic              req_hit;
    logic [6:0]        req_idx;

    assign sel_idx   = grant_q[IDX_W-1:0];
    assign valid_ext = 64'(s_axis_tvalid);
    assign locked    = (state_q == LOCKED);

    assign sel_valid = s_axis_tvalid[sel_idx];
    assign sel_last  = s_axis_tlast[sel_idx];
    assign sel_data  = s_axis_tdata[int'(sel_idx)*DATA_W +: DATA_W];
    assign sel_keep  = s_axis_tkeep[int'(sel_idx)*KEEP_W +: KEEP_W];

    assign beat_acc  = locked && sel_valid && slice_ready;
    assign pkt_done  = beat_acc && sel_last;

    // Only the locked channel ever sees ready; it follows the slice load term
    always_comb begin
        s_axis_tready = '0;
        if (locked) begin
            s_axis_tready[sel_idx] = slice_ready;
        end
    end

    // Grant request seen in IDLE; out-of-range or disabled selects never hit
    always_comb begin
        if (MODE == 0) begin
            req_idx = bus_sel[6:0];
            req_hit = bus_sel[BUS_SEL_EN_BIT]
                   && (int'(bus_sel[6:0]) < N_CH)
                   && valid_ext[bus_sel[5:0]];
        end else begin
            req_idx = rr_next(valid_ext, rr_last_q, N_CH);
            req_hit = |s_axis_tvalid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            rr_last_q <= 7'(N_CH - 1);
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_hit) begin
                        grant_q <= req_idx;
                        state_q <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (pkt_done) begin
                        rr_last_q <= grant_q;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant_idx = grant_q;
    assign busy      = locked;

    axis_reg_slice #(
        .DATA_W (DATA_W),
        .KEEP_W (KEEP_W)
    ) u_out_slice (
        .clk_i      (clk),
        .rst_i      (rst),
        .s_tvalid_i (locked && sel_valid),
        .s_tready_o (slice_ready),
        .s_tdata_i  (sel_data),
        .s_tkeep_i  (sel_keep),
        .s_tlast_i  (sel_last),
        .m_tvalid_o (m_axis_tvalid),
        .m_tready_i (m_axis_tready),
        .m_tdata_o  (m_axis_tdata),
        .m_tkeep_o  (m_axis_tkeep),
        .m_tlast_o  (m_axis_tlast)
    );

endmodule

// File: tb/tb_axis_pkt_arb_mux.sv
// tb/tb_axis_pkt_arb_mux.sv - directed self-checking bench for axis_pkt_arb_mux
module tb_axis_pkt_arb_mux;
    import axis_mux_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // MODE 0 instance
    logic [7:0]   bus_sel0;
    logic [3:0]   s_tvalid0, s_tready0, s_tlast0;
    logic [127:0] s_tdata0;
    logic [15:0]  s_tkeep0;
    logic         m_tvalid0, m_tready0, m_tlast0, busy0, done0;
    logic [31:0]  m_tdata0;
    logic [3:0]   m_tkeep0;
    logic [6:0]   grant0;

    // MODE 1 instance
    logic [7:0]   bus_sel1;
    logic [3:0]   s_tvalid1, s_tready1, s_tlast1;
    logic [127:0] s_tdata1;
    logic [15:0]  s_tkeep1;
    logic         m_tvalid1, m_tready1, m_tlast1, busy1, done1;
    logic [31:0]  m_tdata1;
    logic [3:0]   m_tkeep1;
    logic [6:0]   grant1;

    axis_pkt_arb_mux #(.N_CH(4), .DATA_W(32), .MODE(0)) dut0 (
        .clk(clk), .rst(rst), .bus_sel(bus_sel0),
        .s_axis_tvalid(s_tvalid0), .s_axis_tready(s_tready0),
        .s_axis_tdata(s_tdata0), .s_axis_tkeep(s_tkeep0), .s_axis_tlast(s_tlast0),
        .m_axis_tvalid(m_tvalid0), .m_axis_tready(m_tready0),
        .m_axis_tdata(m_tdata0), .m_axis_tkeep(m_tkeep0), .m_axis_tlast(m_tlast0),
        .grant_idx(grant0), .busy(busy0), .pkt_done(done0)
    );

    axis_pkt_arb_mux #(.N_CH(4), .DATA_W(32), .MODE(1)) dut1 (
        .clk(clk), .rst(rst), .bus_sel(bus_sel1),
        .s_axis_tvalid(s_tvalid1), .s_axis_tready(s_tready1),
        .s_axis_tdata(s_tdata1), .s_axis_tkeep(s_tkeep1), .s_axis_tlast(s_tlast1),
        .m_axis_tvalid(m_tvalid1), .m_axis_tready(m_tready1),
        .m_axis_tdata(m_tdata1), .m_axis_tkeep(m_tkeep1), .m_axis_tlast(m_tlast1),
        .grant_idx(grant1), .busy(busy1), .pkt_done(done1)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic        acc_in, acc_out, stall;
        logic [31:0] held_d;
        logic        held_l;
        int          k, j, nin, nout;
        logic [31:0] exp4 [6];

        rst = 1'b1;
        bus_sel0 = '0; s_tvalid0 = '0; s_tlast0 = '0; s_tdata0 = '0; s_tkeep0 = '1; m_tready0 = 1'b1;
        bus_sel1 = '0; s_tvalid1 = '0; s_tlast1 = '0; s_tdata1 = '0; s_tkeep1 = '1; m_tready1 = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // reset state
        chk("rst_mvalid", m_tvalid0, 0);
        chk("rst_mdata",  m_tdata0, 0);
        chk("rst_busy",   busy0, 0);
        chk("rst_sready", s_tready0, 0);
        chk("rst_grant",  grant0, 0);
        chk("rst_done",   done0, 0);

        // 3-beat packet on ch1
        bus_sel0 = choose_code(7'd1);
        s_tvalid0 = 4'b0010; s_tdata0[32 +: 32] = 32'hA1; s_tlast0 = 4'b0000;
        #1;
        chk("s1_idle_rdy", s_tready0, 0);
        tick();
        chk("s1_busy",  busy0, 1);
        chk("s1_grant", grant0, 1);
        chk("s1_rdy",   s_tready0, 4'b0010);
        tick();
        chk("s1_v1", m_tvalid0, 1);
        chk("s1_d1", m_tdata0, 32'hA1);
        chk("s1_l1", m_tlast0, 0);
        s_tdata0[32 +: 32] = 32'hA2;
        tick();
        chk("s1_d2", m_tdata0, 32'hA2);
        s_tdata0[32 +: 32] = 32'hA3; s_tlast0 = 4'b0010;
        #1;
        chk("s1_done", done0, 1);
        tick();
        chk("s1_d3",    m_tdata0, 32'hA3);
        chk("s1_l3",    m_tlast0, 1);
        chk("s1_idle",  busy0, 0);
        chk("s1_done0", done0, 0);
        s_tvalid0 = '0; s_tlast0 = '0;
        tick();
        chk("s1_drain", m_tvalid0, 0);

        // bus_sel change mid-packet is ignored until tlast
        bus_sel0 = choose_code(7'd0);
        s_tvalid0 = 4'b0101; s_tlast0 = 4'b0100;
        s_tdata0[0 +: 32] = 32'hB0; s_tdata0[64 +: 32] = 32'hC0;
        tick();
        chk("s2_grant0", grant0, 0);
        tick();
        chk("s2_b0", m_tdata0, 32'hB0);
        s_tdata0[0 +: 32] = 32'hB1;
        tick();
        chk("s2_b1", m_tdata0, 32'hB1);
        bus_sel0 = 8'h82;
        s_tdata0[0 +: 32] = 32'hB2;
        #1;
        chk("s2_rdy_only0", s_tready0, 4'b0001);
        tick();
        chk("s2_b2", m_tdata0, 32'hB2);
        chk("s2_still0", grant0, 0);
        s_tdata0[0 +: 32] = 32'hB3; s_tlast0 = 4'b0101;
        #1;
        chk("s2_done", done0, 1);
        tick();
        chk("s2_b3", m_tdata0, 32'hB3);
        chk("s2_b3l", m_tlast0, 1);
        chk("s2_idle", busy0, 0);
        chk("s2_rdy_idle", s_tready0, 0);
        s_tvalid0 = 4'b0100; s_tlast0 = 4'b0100;
        tick();
        chk("s2_grant2", grant0, 2);
        chk("s2_rdy2", s_tready0, 4'b0100);
        chk("s2_bubble", m_tvalid0, 0);
        tick();
        chk("s2_c0", m_tdata0, 32'hC0);
        chk("s2_c0l", m_tlast0, 1);
        chk("s2_end", busy0, 0);
        s_tvalid0 = '0; s_tlast0 = '0; bus_sel0 = 8'h00;
        tick();

        // disabled and out-of-range selects never grant
        s_tvalid0 = 4'b1111;
        tick();
        tick();
        chk("s3_off_busy", busy0, 0);
        chk("s3_off_rdy",  s_tready0, 0);
        chk("s3_off_mv",   m_tvalid0, 0);
        bus_sel0 = 8'h85;
        tick();
        tick();
        chk("s3_oor_busy", busy0, 0);
        chk("s3_oor_rdy",  s_tready0, 0);
        chk("s3_oor_mv",   m_tvalid0, 0);
        s_tvalid0 = '0; bus_sel0 = 8'h00;
        tick();

        // MODE 1 round-robin over four 1-beat streams
        exp4 = '{32'h10, 32'h11, 32'h12, 32'h13, 32'h10, 32'h11};
        for (int i = 0; i < 4; i++) s_tdata1[i*32 +: 32] = 32'h10 + 32'(i);
        s_tlast1 = 4'b1111; s_tvalid1 = 4'b1111; m_tready1 = 1'b1;
        nin = 0; nout = 0;
        for (int c = 0; c < 60 && nout < 6; c++) begin
            acc_in = |(s_tready1 & s_tvalid1);
            if (m_tvalid1 && m_tready1) begin
                chk("s4_order", m_tdata1, exp4[nout]);
                nout++;
            end
            tick();
            if (acc_in) nin++;
            if (nin == 6) s_tvalid1 = '0;
        end
        chk("s4_count", nout, 6);

        // output backpressure over a 5-beat ch3 packet
        bus_sel0 = choose_code(7'd3);
        s_tvalid0 = 4'b1000; s_tdata0[96 +: 32] = 32'hD0; s_tlast0 = '0;
        k = 0; j = 0;
        for (int c = 0; c < 60 && j < 5; c++) begin
            m_tready0 = (c % 3 == 0);
            #1;
            acc_in  = s_tready0[3] & s_tvalid0[3];
            acc_out = m_tvalid0 & m_tready0;
            stall   = m_tvalid0 & !m_tready0;
            held_d  = m_tdata0;
            held_l  = m_tlast0;
            if (stall) chk("s5_rdy_full", s_tready0[3], 0);
            if (acc_out) begin
                chk("s5_data", m_tdata0, 32'hD0 + 32'(j));
                chk("s5_last", m_tlast0, (j == 4));
                j++;
            end
            tick();
            if (stall) begin
                chk("s5_hold_v", m_tvalid0, 1);
                chk("s5_hold_d", m_tdata0, held_d);
                chk("s5_hold_l", m_tlast0, held_l);
            end
            if (acc_in) begin
                k++;
                if (k < 5) begin
                    s_tdata0[96 +: 32] = 32'hD0 + 32'(k);
                    s_tlast0 = (k == 4) ? 4'b1000 : 4'b0000;
                end else begin
                    s_tvalid0 = '0;
                    s_tlast0  = '0;
                end
            end
        end
        chk("s5_out_cnt", j, 5);
        chk("s5_in_cnt",  k, 5);
        m_tready0 = 1'b1;
        tick();
        chk("s5_idle", busy0, 0);

        // reset in the middle of a ch0 packet
        bus_sel0 = choose_code(7'd0);
        s_tvalid0 = 4'b0001; s_tdata0[0 +: 32] = 32'hE0; s_tlast0 = '0;
        tick();
        tick();
        chk("s6_e0", m_tdata0, 32'hE0);
        s_tdata0[0 +: 32] = 32'hE1;
        s_tvalid1 = 4'b1111;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("s6_mv",    m_tvalid0, 0);
        chk("s6_busy",  busy0, 0);
        chk("s6_rdy",   s_tready0, 0);
        chk("s6_grant", grant0, 0);
        chk("s6_busy1", busy1, 0);
        s_tvalid0 = '0;
        tick();
        chk("s6_rr_busy",  busy1, 1);
        chk("s6_rr_fresh", grant1, 0);
        s_tvalid1 = '0;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axis_pkt_arb_mux.md
Name: axis_pkt_arb_mux

Overview:
- Parametrised N-input AXI-Stream packet multiplexer with full tready backpressure; successor to the 4-input combinational bus_sel mux.
- Locks onto one input for a whole packet (through tlast) and never switches mid-packet.
- Selection is either external (bus_sel, same 128+index encoding as before) or internal round-robin.
- Output is a registered slice; sits between the per-channel FIFOs and the shared downstream stream consumer.

Parameters:
- N_CH, 4, number of input channels (2..64)
- DATA_W, 32, tdata width in bits (multiple of 8)
- KEEP_W, DATA_W/8, tkeep width
- MODE, 0, 0 = external select via bus_sel; 1 = round-robin (bus_sel ignored)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- bus_sel  in  8  bit7 = enable, bits6:0 = channel index; 8'd0 = no channel
- s_axis_tvalid  in  N_CH  per-channel valid
- s_axis_tready  out  N_CH  per-channel ready
- s_axis_tdata  in  N_CH*DATA_W  channel i at [i*DATA_W +: DATA_W]
- s_axis_tkeep  in  N_CH*KEEP_W  packed the same way as tdata
- s_axis_tlast  in  N_CH  per-channel last
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- m_axis_tdata  out  DATA_W  output data
- m_axis_tkeep  out  KEEP_W  output keep
- m_axis_tlast  out  1  output last
- grant_idx  out  7  channel currently locked (valid when busy)
- busy  out  1  1 while a packet is locked
- pkt_done  out  1  one-cycle pulse when the tlast beat is accepted on the input side

Behaviour:
- Reset: m_axis_tvalid, tdata, tkeep, tlast = 0; s_axis_tready = 0; busy = 0; grant_idx = 0; pkt_done = 0; state IDLE; rr_last = N_CH-1, so channel 0 has first priority.
- Slice load condition: load = !m_axis_tvalid || m_axis_tready. One beat per cycle at full throughput; input-to-output latency is 1 cycle.
- FSM states: IDLE, LOCKED.
- IDLE, MODE 0:
  - If bus_sel[7] = 1, bus_sel[6:0] < N_CH and that channel's tvalid = 1: register grant_idx = bus_sel[6:0] and go to LOCKED next cycle.
  - Otherwise stay in IDLE. All s_axis_tready = 0 in IDLE.
  - Out-of-range or disabled bus_sel never grants. This replaces the old default-zero output.
- IDLE, MODE 1: grant the first valid channel searching from rr_last+1 upward with wrap-around at N_CH-1 -> 0. Go to LOCKED.
- LOCKED:
  - s_axis_tready[grant_idx] = load; all other ready bits = 0. Ready is combinational from state and m_axis_tready.
  - An input beat is accepted when tvalid & tready; the slice captures tdata, tkeep and tlast.
  - If no beat is accepted but the output is taken, m_axis_tvalid drops to 0.
  - When the accepted beat has tlast = 1: pkt_done = 1 that cycle, rr_last <= grant_idx, go to IDLE.
  - The earliest next grant is the following cycle, so there is one bubble cycle between packets.
- Changes to bus_sel while LOCKED are ignored until packet end.
- A locked channel dropping tvalid mid-packet simply stalls; the lock is held.
- Simultaneous m_axis_tready = 1 and a new input beat: the output is replaced in the same cycle with no loss.
- m_axis_* hold stable while m_axis_tvalid = 1 and m_axis_tready = 0 (AXIS rule).
- rst asserted mid-packet: all outputs return to reset values next edge and the partial packet is discarded. The bench must not expect a completed tlast.
- Channel index width is fixed at 7 bits; widths are derived with $clog2 internally.

Decomposition:
- Package axis_mux_pkg holds:
  - the state enum (IDLE, LOCKED)
  - BUS_SEL_EN_BIT = 7
  - the function choose_code(idx) = 8'd128 + idx
  - the round-robin next-index function
- One natural sub-module: axis_reg_slice (single-stage AXIS register, DATA_W/KEEP_W parameters) for the output stage.
- The arbiter FSM and the per-channel index/ready logic stay in the top module.

Test Plan:
- MODE 0, bus_sel = 8'h81, ch1 sends a 3-beat packet (0xA1, 0xA2, 0xA3 with tlast) and m_tready = 1 -> the same 3 beats appear in order with 1-cycle latency; pkt_done pulses once; busy returns to 0.
- MODE 0, bus_sel changed from 8'h80 to 8'h82 after beat 2 of a 4-beat ch0 packet -> all 4 ch0 beats are output; ch2 is granted only after ch0's tlast; s_tready[2] stays 0 until then.
- MODE 0, bus_sel = 8'h00, then 8'h85 with N_CH = 4 -> no grant; all s_tready = 0; m_tvalid stays 0.
- MODE 1, all 4 channels continuously sending 1-beat packets -> grant order 0, 1, 2, 3, 0, ...; each channel gets 1 of every 4 packets.
- m_tready toggled 1,0,0,1,... during a 5-beat packet -> no beat lost or duplicated; m_axis_* held stable while stalled; s_tready deasserts whenever the slice is full and m_tready = 0.
- rst pulsed on beat 2 of a 4-beat packet -> next cycle m_tvalid = 0, busy = 0, s_tready = 0; the next packet is granted fresh starting from channel 0 priority.
